// File: rtl/replacement_way_select_pkg.sv
// Shared definitions for the cache way-replacement logic: the log2 helper,
// the PLRU node count and the flush FSM state encoding.
package replacement_way_select_pkg;

  localparam int DEFAULT_WAYS = 4;
  localparam int DEFAULT_SETS = 16;

  // A binary tree over N leaves has N-1 internal nodes.
  localparam int PLRU_NODES = DEFAULT_WAYS - 1;

  // Flush sequencer encoding, kept as plain constants for older tool flows.
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  // Ceiling log2, used for index widths and the tree depth.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

  // PLRU node count for an arbitrary associativity.
  function automatic int plru_nodes(input int ways);
    return ways - 1;
  endfunction

endpackage

// File: rtl/replacement_way_select_plru_tree_logic.sv
// Combinational tree-PLRU helpers: walks a set's node bits down to the victim
// leaf, and computes the node bits that result from touching a way.
module plru_tree_logic
  import replacement_way_select_pkg::*;
#(
  parameter int NUMBER_OF_WAYS = DEFAULT_WAYS
) (
  input  logic [NUMBER_OF_WAYS-2:0] lookup_nodes,
  output logic [NUMBER_OF_WAYS-1:0] plru_way,
  input  logic [NUMBER_OF_WAYS-2:0] touch_nodes,
  input  logic [NUMBER_OF_WAYS-1:0] touch_way,
  output logic [NUMBER_OF_WAYS-2:0] next_nodes
);

  localparam int NODES = plru_nodes(NUMBER_OF_WAYS);
  localparam int TREE  = 2 * NUMBER_OF_WAYS - 1;

  // Heap-ordered tree: internal nodes 0..NODES-1, leaves NODES..TREE-1 map to
  // ways 0..NUMBER_OF_WAYS-1 from left to right.
  logic [TREE-1:0]           reach;
  logic [TREE-1:1]           hit;
  logic [NUMBER_OF_WAYS-1:0] touch_lowest;

  // Only the lowest set bit of the touch vector counts as the accessed way.
  assign touch_lowest = touch_way & (~touch_way + 1'b1);

  // Mark every node reached by following the node bits from the root.
  always_comb begin
    reach    = '0;
    reach[0] = 1'b1;
    for (int i = 1; i < TREE; i++) begin
      if ((i % 2) == 0) begin
        reach[i] = reach[(i - 1) / 2] & lookup_nodes[(i - 1) / 2];
      end else begin
        reach[i] = reach[(i - 1) / 2] & ~lookup_nodes[(i - 1) / 2];
      end
    end
  end

  assign plru_way = reach[TREE-1:NODES];

  // Point every node on the touched path toward the other subtree.
  always_comb begin
    hit               = '0;
    hit[TREE-1:NODES] = touch_lowest;
    for (int i = NODES - 1; i >= 1; i--) begin
      hit[i] = hit[2 * i + 1] | hit[2 * i + 2];
    end
    next_nodes = touch_nodes;
    for (int i = 0; i < NODES; i++) begin
      if (hit[2 * i + 1]) begin
        next_nodes[i] = 1'b1;
      end else if (hit[2 * i + 2]) begin
        next_nodes[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/replacement_way_select.sv
// Per-set tree pseudo-LRU victim selector. Prefers an unused way, otherwise
// returns the PLRU victim; records hits/fills and supports a flush sweep.
module replacement_way_select
  import replacement_way_select_pkg::*;
#(
  parameter int NUMBER_OF_WAYS = DEFAULT_WAYS,
  parameter int NUMBER_OF_SETS = DEFAULT_SETS,
  parameter int INDEX_BITS     = log2(NUMBER_OF_SETS)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      query_valid,
  input  logic [INDEX_BITS-1:0]     query_index,
  input  logic [NUMBER_OF_WAYS-1:0] ways_in_use,
  input  logic                      touch_valid,
  input  logic [INDEX_BITS-1:0]     touch_index,
  input  logic [NUMBER_OF_WAYS-1:0] touch_way,
  input  logic                      flush,
  output logic                      busy,
  output logic                      victim_valid,
  output logic [NUMBER_OF_WAYS-1:0] victim_way,
  output logic                      victim_is_empty
);

  localparam int NODES = plru_nodes(NUMBER_OF_WAYS);
  localparam logic [INDEX_BITS-1:0] LAST_SET = INDEX_BITS'(NUMBER_OF_SETS - 1);

  logic [NODES-1:0]          plru_state [NUMBER_OF_SETS];
  logic [0:0]                state;
  logic [INDEX_BITS-1:0]     sweep_count;
  logic [NODES-1:0]          lookup_nodes;
  logic [NODES-1:0]          touch_nodes;
  logic [NODES-1:0]          next_nodes;
  logic [NUMBER_OF_WAYS-1:0] plru_way;
  logic [NUMBER_OF_WAYS-1:0] empty_way;
  logic                      set_full;
  logic                      accept_query;
  logic                      accept_touch;

  assign busy         = (state == FLUSH);
  assign accept_query = query_valid && !busy;
  assign accept_touch = touch_valid && !busy;

  assign lookup_nodes = plru_state[query_index];
  assign touch_nodes  = plru_state[touch_index];

  // Lowest-numbered zero in the valid bits is the preferred fill target.
  assign set_full  = &ways_in_use;
  assign empty_way = ~ways_in_use & (ways_in_use + 1'b1);

  plru_tree_logic #(
    .NUMBER_OF_WAYS(NUMBER_OF_WAYS)
  ) u_plru_tree_logic (
    .lookup_nodes(lookup_nodes),
    .plru_way    (plru_way),
    .touch_nodes (touch_nodes),
    .touch_way   (touch_way),
    .next_nodes  (next_nodes)
  );

  // Flush sequencer: one set cleared per cycle, back to IDLE after the last.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      sweep_count <= '0;
    end else if (state == IDLE) begin
      if (flush) begin
        state       <= FLUSH;
        sweep_count <= '0;
      end
    end else begin
      if (sweep_count == LAST_SET) begin
        state <= IDLE;
      end
      sweep_count <= sweep_count + 1'b1;
    end
  end

  // PLRU node storage: cleared by reset or the sweep, updated on touches.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < NUMBER_OF_SETS; s++) begin
        plru_state[s] <= '0;
      end
    end else if (busy) begin
      plru_state[sweep_count] <= '0;
    end else if (accept_touch) begin
      plru_state[touch_index] <= next_nodes;
    end
  end

  // Registered lookup result; way/empty hold between lookups.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      victim_valid    <= 1'b0;
      victim_way      <= '0;
      victim_is_empty <= 1'b0;
    end else begin
      victim_valid <= accept_query;
      if (accept_query) begin
        victim_way      <= set_full ? plru_way : empty_way;
        victim_is_empty <= !set_full;
      end
    end
  end

endmodule

// File: doc/replacement_way_select.md
# replacement_way_select

Per-set tree pseudo-LRU victim selector for the set-associative cache controller. It handles the eviction side of way management. On a lookup it returns the way to fill next: the lowest-numbered unused way if the set has one, otherwise the PLRU victim. It records every hit and fill so the PLRU state tracks recent use, and supports a multi-cycle flush that sweeps the PLRU state.

## Interface
- NUMBER_OF_WAYS, 4, associativity; power of two, at least 2
- NUMBER_OF_SETS, 16, number of sets; power of two
- INDEX_BITS, log2(NUMBER_OF_SETS), set index width
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high
- query_valid  in  1  victim lookup request, single-cycle pulse
- query_index  in  INDEX_BITS  set being looked up
- ways_in_use  in  NUMBER_OF_WAYS  valid bits of the queried set, sampled with query_valid
- touch_valid  in  1  access notification (hit or fill)
- touch_index  in  INDEX_BITS  set accessed
- touch_way  in  NUMBER_OF_WAYS  one-hot way accessed
- flush  in  1  start a PLRU state clear sweep
- busy  out  1  flush sweep in progress
- victim_valid  out  1  victim_way and victim_is_empty are valid this cycle
- victim_way  out  NUMBER_OF_WAYS  one-hot selected way
- victim_is_empty  out  1  selected way was unused, so no writeback is needed

## Operation
- PLRU state: NUMBER_OF_SETS × (NUMBER_OF_WAYS−1) node bits, in heap order with node 0 as the root and children of node i at 2i+1 and 2i+2.
  - A node bit of 0 means the next victim is in the lower-numbered subtree; 1 means the higher-numbered subtree.
- Victim decode:
  - If ways_in_use is not all ones, select the lowest-index zero bit of ways_in_use and set victim_is_empty=1.
  - Otherwise walk the tree from the root following the node bits, and set victim_is_empty=0.
- Touch update: for every node on the path to touch_way, set the bit to point away from touch_way. Nodes off the path are unchanged.
- touch_way handling:
  - If touch_way is all zeros, no update.
  - If touch_way has more than one bit set, only the lowest set bit is used.
- A touch does not change the victim outputs of a lookup already in flight.
- FSM states and transitions:
  - IDLE → FLUSH when flush=1.
  - FLUSH: a sweep counter clears set k in sweep cycle k.
  - FLUSH → IDLE after set NUMBER_OF_SETS−1 is cleared.
- While busy=1:
  - query_valid, touch_valid and flush are ignored.
  - No victim_valid is produced.
- Reset:
  - All PLRU bits cleared, FSM to IDLE, counter to 0.
  - busy=0, victim_valid=0, victim_way=0, victim_is_empty=0.
  - Reset asserted mid-flush aborts the sweep; the state is fully cleared anyway.

## Timing
- Lookup latency is 1 cycle: query_valid at edge N gives registered outputs with victim_valid=1 during cycle N+1, for exactly one cycle.
- Throughput: one query per cycle. Back-to-back queries produce back-to-back victim_valid.
- victim_way and victim_is_empty hold their last value while victim_valid=0.
- A touch at edge N updates the state at edge N; a query at N+1 sees the update.
- Same-cycle query and touch to the same index: the query decodes the pre-touch state, and the touch still commits.
- Two same-cycle touches cannot occur (single port).
- Flush sampled at edge N (IDLE):
  - busy=1 from N+1 for exactly NUMBER_OF_SETS cycles.
  - busy=0 again at N+1+NUMBER_OF_SETS, when new requests are accepted.
- An index wider than the set count cannot occur, since sets are a power of two and the index wraps naturally.

## Structure
- Shared cache package holds:
  - the log2 function
  - the PLRU_NODES = NUMBER_OF_WAYS−1 constant
  - the FSM state encoding (IDLE, FLUSH)
- One combinational sub-module, plru_tree_logic. It takes the node bits and produces the victim one-hot, and from a touched way produces the next node bits.
  - The top level holds the state array, the output registers and the flush FSM.

## Test plan
All scenarios use NUMBER_OF_WAYS=4, with nodes b0 (root), b1 (ways 0/1) and b2 (ways 2/3).
- After reset, query index 3 with ways_in_use=4'b1111 → next cycle victim_valid=1, victim_way=4'b0001, victim_is_empty=0.
- Query with ways_in_use=4'b1011 → victim_way=4'b0100, victim_is_empty=1, regardless of PLRU state.
- Touch index 5 way 4'b0001, then query 5 full → victim_way=4'b0100. Then touch way 4'b0100 and query → victim_way=4'b0010. Index 6 is unaffected and still returns 4'b0001.
- Same cycle: query and touch of index 2, way 4'b0001 → victim 4'b0001 (pre-touch). A query on the next cycle → 4'b0100.
- Touch several sets, then pulse flush → busy high exactly 16 cycles, and queries during busy give no victim_valid. After busy falls, every set returns 4'b0001 when full.
- Assert reset 5 cycles into a flush → busy=0 immediately (asynchronous) and all outputs 0. After release, a full-set query returns 4'b0001.
